// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module      : decoder_3to8
// Description : Enabled 3-to-8 one-hot decoder (big-endian, q[0] for sel=0)
//               with last-code, activity and strobe-count bookkeeping.
//               Define DECODER_OUT_REG_EN to register q/any (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_3to8 #(
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 8,
  localparam int OUT_WIDTH = 2 ** SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 en,
  input  logic [0:SEL_WIDTH-1] sel,
  output logic [0:OUT_WIDTH-1] q,
  output logic                 any,
  output logic [0:SEL_WIDTH-1] lastSel,
  output logic                 lastValid,
  output logic [0:CNT_WIDTH-1] strobeCount
);

  localparam logic [0:CNT_WIDTH-1] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:OUT_WIDTH-1] w_decode;
  logic [0:SEL_WIDTH-1] r_last_sel;
  logic                 r_last_valid;
  logic [0:CNT_WIDTH-1] r_strobe_count;

  // Ascending range: w_decode[0] is the leftmost bit, so sel=0 lands on the MSB.
  always_comb begin
    w_decode = '0;
    if (en) begin
      w_decode[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_last_sel     <= '0;
      r_last_valid   <= 1'b0;
      r_strobe_count <= '0;
    end else if (en) begin
      r_last_sel     <= sel;
      r_last_valid   <= 1'b1;
      r_strobe_count <= r_strobe_count + c_cnt_one;
    end
  end

`ifdef DECODER_OUT_REG_EN
  logic [0:OUT_WIDTH-1] r_q;
  logic                 r_any;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q   <= '0;
      r_any <= 1'b0;
    end else begin
      r_q   <= w_decode;
      r_any <= |w_decode;
    end
  end

  assign q   = r_q;
  assign any = r_any;
`else
  assign q   = w_decode;
  assign any = |w_decode;
`endif

  assign lastSel     = r_last_sel;
  assign lastValid   = r_last_valid;
  assign strobeCount = r_strobe_count;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// Testbench for decoder_3to8: vector table plus scoreboarded sequences
// covering decode, enable gating, bookkeeping, wrap and async reset.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       en = 1'b0;
  logic [0:2] sel = '0;
  logic [0:7] q;
  logic       any;
  logic [0:2] lastSel;
  logic       lastValid;
  logic [0:7] strobeCount;

  decoder_3to8 dut (
    .clk         (clk),
    .resetN      (resetN),
    .en          (en),
    .sel         (sel),
    .q           (q),
    .any         (any),
    .lastSel     (lastSel),
    .lastValid   (lastValid),
    .strobeCount (strobeCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic [7:0] exp_q;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       any;
    logic [2:0] last_sel;
    logic       last_valid;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] m_last = '0;
  logic       m_valid = 1'b0;
  logic [7:0] m_cnt = '0;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ls, input logic lv, input logic [7:0] c);
    chk({tag, ".lastSel"}, 32'(lastSel), 32'(ls));
    chk({tag, ".lastValid"}, 32'(lastValid), 32'(lv));
    chk({tag, ".strobeCount"}, 32'(strobeCount), 32'(c));
  endtask

  // Drive at negedge, predict post-edge values, compare just after the posedge.
  task automatic step(input string tag, input logic e, input logic [2:0] s, input logic [7:0] eq);
    exp_t x;
    exp_t got;
    @(negedge clk);
    en  = e;
    sel = s;
    if (e) begin
      m_last  = s;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end
    x.q = eq; x.any = |eq; x.last_sel = m_last; x.last_valid = m_valid; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".q"}, 32'(q), 32'(got.q));
    chk({tag, ".any"}, 32'(any), 32'(got.any));
    chk_state(tag, got.last_sel, got.last_valid, got.cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    en     = 1'b0;
    #1;
    m_last = '0; m_valid = 1'b0; m_cnt = '0;
    chk_state("reset", 3'd0, 1'b0, 8'd0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0] = '{1'b1, 3'd0, 8'h80};  tbl[1] = '{1'b1, 3'd1, 8'h40};
    tbl[2] = '{1'b1, 3'd2, 8'h20};  tbl[3] = '{1'b1, 3'd3, 8'h10};
    tbl[4] = '{1'b1, 3'd4, 8'h08};  tbl[5] = '{1'b1, 3'd5, 8'h04};
    tbl[6] = '{1'b1, 3'd6, 8'h02};  tbl[7] = '{1'b1, 3'd7, 8'h01};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b0, 3'(i), 8'h00};

    // Reset state
    #2;
    chk_state("init", 3'd0, 1'b0, 8'd0);
    chk("init.q", 32'(q), 32'h0);
    chk("init.any", 32'(any), 32'h0);
    @(negedge clk);
    resetN = 1'b1;

    // Exhaustive decode followed by enable gating (state must hold at sel=7, count 8)
    for (int i = 0; i < 16; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].sel, tbl[i].exp_q);
    end
    chk_state("gated", 3'd7, 1'b1, 8'd8);

    // Bookkeeping after reset
    do_reset();
    step("bk0", 1'b1, 3'd5, 8'h04);
    step("bk1", 1'b1, 3'd2, 8'h20);
    step("bk2", 1'b1, 3'd6, 8'h02);
    chk_state("bk", 3'd6, 1'b1, 8'd3);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step("wrap", 1'b1, 3'(i), 8'h80 >> (i % 8));
    end
    chk_state("wrapped", 3'd7, 1'b1, 8'd0);

    // Async reset between edges, enabled edges during reset do not count
    do_reset();
    for (int i = 0; i < 10; i++) step("pre", 1'b1, 3'd1, 8'h40);
    chk("pre.cnt", 32'(strobeCount), 32'd10);
    #2;
    resetN = 1'b0;
    en = 1'b1;
    sel = 3'd7;
    #1;
    m_last = '0; m_valid = 1'b0; m_cnt = '0;
    chk_state("async", 3'd0, 1'b0, 8'd0);
`ifdef DECODER_OUT_REG_EN
    chk("async.q", 32'(q), 32'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_state("inrst", 3'd0, 1'b0, 8'd0);
    end
    @(negedge clk);
    resetN = 1'b1;
    en = 1'b0;
    step("post", 1'b1, 3'd4, 8'h08);
    chk("post.cnt", 32'(strobeCount), 32'd1);

    // Output timing: combinational in default build, one cycle late when registered
    step("lat0", 1'b1, 3'd0, 8'h80);
    @(negedge clk);
    en = 1'b1;
    sel = 3'd3;
    #1;
`ifdef DECODER_OUT_REG_EN
    chk("lat.before", 32'(q), 32'h80);
`else
    chk("lat.before", 32'(q), 32'h10);
`endif
    @(posedge clk);
    #1;
    chk("lat.after", 32'(q), 32'h10);
    chk("lat.cnt", 32'(strobeCount), 32'd3);
    resetN = 1'b0;
    #1;
    chk("lat.rstvalid", 32'(lastValid), 32'd0);
`ifdef DECODER_OUT_REG_EN
    chk("lat.rstq", 32'(q), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
